// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 32-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int NUM_REQ = 32;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/decoder_5to32.sv
// Binary-to-one-hot decoder, 5-bit index to 32-bit mask.
// Latency: combinational.
// Backpressure: none.
module decoder_5to32 (
    input  logic [4:0]  a_i,
    output logic [31:0] out_o
);

    always_comb begin
        out_o = '0;
        out_o[a_i] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter granting one of 32 requesters, held until release, drop or hold limit.
// Latency: grant visible one edge after the request is sampled; one idle cycle between grants.
// Backpressure: owner holds until release_i, its request drops, or HOLD_MAX cycles elapse.
module rr_arbiter_32
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               release_i,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W:0]      pick;
    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic                owner_rel;
    logic                owner_drop;
    logic                hold_hit;
    logic                grant_end;
    logic [NUM_REQ-1:0]  grant_mask;

    // First set request at or after base, wrapping modulo 32; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   base
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = base + IDX_W'(i);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign pick     = rr_pick(req_i, ptr);
    assign pick_vld = pick[IDX_W];
    assign pick_idx = pick[IDX_W-1:0];

    assign owner_rel  = release_i;
    assign owner_drop = ~req_i[grant_idx_o];
    assign hold_hit   = (cnt == CNT_LAST);
    assign grant_end  = owner_rel | owner_drop | hold_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            cnt           <= '0;
            grant_valid_o <= 1'b0;
            grant_idx_o   <= '0;
            timeout_o     <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            if (state == ST_IDLE) begin
                if (pick_vld) begin
                    grant_idx_o   <= pick_idx;
                    grant_valid_o <= 1'b1;
                    cnt           <= '0;
                    state         <= ST_BUSY;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (grant_end) begin
                    grant_valid_o <= 1'b0;
                    state         <= ST_IDLE;
                    ptr           <= grant_idx_o + 1'b1;
                    // A coincident release or drop wins over the hold limit.
                    timeout_o     <= hold_hit & ~owner_rel & ~owner_drop;
                end
            end
        end
    end

    decoder_5to32 u_grant_dec (
        .a_i   (grant_idx_o),
        .out_o (grant_mask)
    );

    assign grant_o = grant_mask & {NUM_REQ{grant_valid_o}};

endmodule

// File: tb/tb_rr_arbiter_32.sv
module tb_rr_arbiter_32;

    localparam int HOLD = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] req_i = '0;
    logic        release_i = 1'b0;
    logic        grant_valid_o;
    logic [4:0]  grant_idx_o;
    logic [31:0] grant_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    // reference model: owner, pointer and number of cycles the current grant has been visible
    logic        m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    int          m_len   = 0;
    logic        m_to    = 1'b0;

    rr_arbiter_32 #(.HOLD_MAX(HOLD)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .release_i     (release_i),
        .grant_valid_o (grant_valid_o),
        .grant_idx_o   (grant_idx_o),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic [31:0] r, input logic rl, input logic rs);
        bit ended;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_len = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (r != 0) begin
                for (int k = 31; k >= 0; k--)
                    if (r[(m_ptr + k) % 32]) m_owner = (m_ptr + k) % 32;
                m_busy = 1;
                m_len  = 1;
            end
        end else begin
            ended = rl || !r[m_owner] || (m_len == HOLD);
            m_to  = (m_len == HOLD) && !rl && r[m_owner];
            if (ended) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 32;
            end else begin
                m_len++;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_grant;
        exp_grant = m_busy ? (32'h1 << m_owner) : 32'h0;
        chk("m_valid", {31'b0, grant_valid_o}, {31'b0, m_busy});
        chk("m_idx", {27'b0, grant_idx_o}, 32'(m_owner));
        chk("m_grant", grant_o, exp_grant);
        chk("m_timeout", {31'b0, timeout_o}, {31'b0, m_to});
    endtask

    task automatic cycle(input logic [31:0] r, input logic rl, input logic rs);
        req_i = r; release_i = rl; rst_i = rs;
        @(posedge clk_i);
        model_step(r, rl, rs);
        #1;
        check_model();
    endtask

    initial begin
        // 1: reset with all requests high
        cycle(32'hFFFF_FFFF, 0, 1);
        cycle(32'hFFFF_FFFF, 0, 1);
        chk("rst_valid", {31'b0, grant_valid_o}, 32'h0);
        chk("rst_grant", grant_o, 32'h0);
        chk("rst_idx", {27'b0, grant_idx_o}, 32'h0);
        chk("rst_timeout", {31'b0, timeout_o}, 32'h0);
        cycle(32'hFFFF_FFFF, 0, 0);
        chk("first_idx", {27'b0, grant_idx_o}, 32'd0);
        chk("first_grant", grant_o, 32'h0000_0001);
        cycle(32'hFFFF_FFFF, 1, 0);
        cycle(32'h0, 0, 0);

        // 2: single request, then scan start at 11
        cycle(32'h0, 0, 1);
        cycle(32'h0000_0400, 0, 0);
        chk("single_idx", {27'b0, grant_idx_o}, 32'd10);
        chk("single_grant", grant_o, 32'h0000_0400);
        cycle(32'h0000_0400, 1, 0);
        chk("single_rel", {31'b0, grant_valid_o}, 32'h0);
        chk("single_rel_idx", {27'b0, grant_idx_o}, 32'd10);
        cycle(32'h0000_0401, 0, 0);
        chk("scan_from_11", {27'b0, grant_idx_o}, 32'd0);
        cycle(32'h0000_0401, 1, 0);

        // 3: rotation and wrap between 0 and 31
        cycle(32'h0, 0, 1);
        for (int g = 0; g < 4; g++) begin
            cycle(32'h8000_0001, 0, 0);
            chk("rot_grant", grant_o, (g % 2 == 0) ? 32'h0000_0001 : 32'h8000_0000);
            cycle(32'h8000_0001, 1, 0);
            chk("rot_gap", {31'b0, grant_valid_o}, 32'h0);
        end

        // 4: timeout after exactly HOLD cycles, then re-grant
        cycle(32'h0, 0, 1);
        for (int c = 0; c < HOLD; c++) begin
            cycle(32'h0000_0020, 0, 0);
            chk("to_hold", {31'b0, grant_valid_o}, 32'h1);
            chk("to_nopulse", {31'b0, timeout_o}, 32'h0);
        end
        cycle(32'h0000_0020, 0, 0);
        chk("to_drop", {31'b0, grant_valid_o}, 32'h0);
        chk("to_pulse", {31'b0, timeout_o}, 32'h1);
        cycle(32'h0000_0020, 0, 0);
        chk("to_regrant", grant_o, 32'h0000_0020);
        chk("to_pulse_end", {31'b0, timeout_o}, 32'h0);

        // 5: owner drops its request
        cycle(32'h0, 0, 1);
        cycle(32'h0010_0000, 0, 0);
        chk("drop_owner", {27'b0, grant_idx_o}, 32'd20);
        cycle(32'h0000_0004, 0, 0);
        chk("drop_end", {31'b0, grant_valid_o}, 32'h0);
        chk("drop_noto", {31'b0, timeout_o}, 32'h0);
        cycle(32'h0000_0004, 0, 0);
        chk("drop_next", {27'b0, grant_idx_o}, 32'd2);

        // 6: release coinciding with hold limit, then reset mid-grant
        cycle(32'h0, 0, 1);
        for (int c = 0; c < HOLD; c++) cycle(32'h0000_0040, 0, 0);
        cycle(32'h0000_0040, 1, 0);
        chk("coinc_end", {31'b0, grant_valid_o}, 32'h0);
        chk("coinc_noto", {31'b0, timeout_o}, 32'h0);
        cycle(32'h0000_0040, 0, 0);
        cycle(32'h0000_0040, 0, 1);
        chk("midrst_valid", {31'b0, grant_valid_o}, 32'h0);
        chk("midrst_grant", grant_o, 32'h0);
        chk("midrst_idx", {27'b0, grant_idx_o}, 32'h0);
        cycle(32'h8000_0001, 0, 0);
        chk("midrst_ptr0", {27'b0, grant_idx_o}, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            r = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 7) == 0) r = 32'h0;
            cycle(r | ((m_busy && $urandom_range(0, 3) != 0) ? (32'h1 << m_owner) : 32'h0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
